// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared stall encodings, exception codes and FSM states for pipe_ctrl
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_e;

  // Per-stage freeze masks: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB.
  // A stage stalls together with every stage upstream of it.
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  localparam logic [31:0] EXC_NONE = 32'h0000_0000;
  localparam logic [31:0] EXC_ERET = 32'h0000_000e;

  // The furthest-downstream requester wins, since its mask covers the others.
  function automatic logic [5:0] stall_encode(input logic id_req, input logic ex_req,
                                              input logic mem_req);
    logic [5:0] enc;
    enc = STALL_NONE;
    if (mem_req)     enc = STALL_MEM;
    else if (ex_req) enc = STALL_EX;
    else if (id_req) enc = STALL_ID;
    return enc;
  endfunction

endpackage

// File: rtl/pipe_stall_cnt.sv
// rtl/pipe_stall_cnt.sv - saturating stall-cycle counter with synchronous clear
module pipe_stall_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Clear beats increment; increment stops once the counter reaches all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Counter register, cleared by the asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/flush controller with exception redirect
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
  parameter int          CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_from_id,
  input  logic             stallreq_from_ex,
  input  logic             stallreq_from_mem,
  input  logic [31:0]      excepttype_i,
  input  logic [31:0]      cp0_epc_i,
  input  logic             perf_clr,
  output logic [5:0]       stall,
  output logic             flush,
  output logic [31:0]      new_pc,
  output logic [CNT_W-1:0] perf_stall_cnt
);

  state_e      state_q, state_d;
  logic [31:0] new_pc_q, new_pc_d;
  logic [5:0]  stall_req;

  assign stall_req = stall_encode(stallreq_from_id, stallreq_from_ex, stallreq_from_mem);

  // Next state and redirect target. The target is computed at the capture
  // edge so that EPC is sampled exactly when the exception is accepted.
  // FLUSH and HOLDOFF both ignore new exceptions.
  always_comb begin
    state_d  = state_q;
    new_pc_d = new_pc_q;
    unique case (state_q)
      ST_RUN: begin
        if (excepttype_i != EXC_NONE) begin
          state_d  = ST_FLUSH;
          new_pc_d = (excepttype_i == EXC_ERET) ? cp0_epc_i : EXC_VECTOR;
        end
      end
      ST_FLUSH:   state_d = ST_HOLDOFF;
      ST_HOLDOFF: state_d = ST_RUN;
      default:    state_d = ST_RUN;
    endcase
  end

  // State and redirect-target registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_RUN;
      new_pc_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      new_pc_q <= new_pc_d;
    end
  end

  // Flush wipes every stage, so no stage may be frozen in that cycle; reset
  // also forces the freeze mask low since the requests are not yet trustworthy.
  always_comb begin
    flush = 1'b0;
    stall = STALL_NONE;
    if (!rst) begin
      flush = 1'b0;
      stall = STALL_NONE;
    end else if (state_q == ST_FLUSH) begin
      flush = 1'b1;
      stall = STALL_NONE;
    end else begin
      stall = stall_req;
    end
  end

  assign new_pc = new_pc_q;

  pipe_stall_cnt #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall != STALL_NONE),
    .clr (perf_clr),
    .cnt (perf_stall_cnt)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed table-driven bench for pipe_ctrl
module tb_pipe_ctrl;

  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic             stallreq_from_id;
  logic             stallreq_from_ex;
  logic             stallreq_from_mem;
  logic [31:0]      excepttype_i;
  logic [31:0]      cp0_epc_i;
  logic             perf_clr;
  logic [5:0]       stall;
  logic             flush;
  logic [31:0]      new_pc;
  logic [CNT_W-1:0] perf_stall_cnt;

  int checks;
  int errors;

  pipe_ctrl #(
    .EXC_VECTOR (32'h0000_0020),
    .CNT_W      (CNT_W)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .stallreq_from_id  (stallreq_from_id),
    .stallreq_from_ex  (stallreq_from_ex),
    .stallreq_from_mem (stallreq_from_mem),
    .excepttype_i      (excepttype_i),
    .cp0_epc_i         (cp0_epc_i),
    .perf_clr          (perf_clr),
    .stall             (stall),
    .flush             (flush),
    .new_pc            (new_pc),
    .perf_stall_cnt    (perf_stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        id;
    logic        ex;
    logic        mem;
    logic [31:0] exc;
    logic [31:0] epc;
    logic        clr;
    logic [5:0]  e_stall;
    logic        e_flush;
    logic [31:0] e_pc;
    logic [3:0]  e_cnt;
  } vec_t;

  vec_t vecs[19];

  function automatic vec_t mk(input logic id, input logic ex, input logic mem,
                              input logic [31:0] exc, input logic [31:0] epc,
                              input logic clr, input logic [5:0] e_stall,
                              input logic e_flush, input logic [31:0] e_pc,
                              input logic [3:0] e_cnt);
    vec_t v;
    v.id = id; v.ex = ex; v.mem = mem; v.exc = exc; v.epc = epc; v.clr = clr;
    v.e_stall = e_stall; v.e_flush = e_flush; v.e_pc = e_pc; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic id, input logic ex, input logic mem,
                       input logic [31:0] exc, input logic [31:0] epc, input logic clr);
    stallreq_from_id  = id;
    stallreq_from_ex  = ex;
    stallreq_from_mem = mem;
    excepttype_i      = exc;
    cp0_epc_i         = epc;
    perf_clr          = clr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [5:0] e_stall, input logic e_flush,
                           input logic [31:0] e_pc, input logic [3:0] e_cnt);
    chk({tag, ".stall"}, {26'h0, stall}, {26'h0, e_stall});
    chk({tag, ".flush"}, {31'h0, flush}, {31'h0, e_flush});
    chk({tag, ".new_pc"}, new_pc, e_pc);
    chk({tag, ".cnt"}, {28'h0, perf_stall_cnt}, {28'h0, e_cnt});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

    // Each row: inputs applied after an edge, outputs checked before the next.
    //                id    ex    mem   exc            epc            clr   stall      fl    new_pc         cnt
    vecs[0]  = mk(1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 6'b000000, 1'b0, 32'h0,         4'd0);
    vecs[1]  = mk(1'b1, 1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 6'b000111, 1'b0, 32'h0,         4'd0);
    vecs[2]  = mk(1'b1, 1'b0, 1'b1, 32'h0,         32'h0,         1'b0, 6'b011111, 1'b0, 32'h0,         4'd1);
    vecs[3]  = mk(1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 6'b000000, 1'b0, 32'h0,         4'd2);
    vecs[4]  = mk(1'b0, 1'b1, 1'b0, 32'h0,         32'h0,         1'b0, 6'b001111, 1'b0, 32'h0,         4'd2);
    vecs[5]  = mk(1'b1, 1'b1, 1'b0, 32'h0,         32'h0,         1'b0, 6'b001111, 1'b0, 32'h0,         4'd3);
    vecs[6]  = mk(1'b0, 1'b0, 1'b0, 32'h8,         32'h1234_5678, 1'b0, 6'b000000, 1'b0, 32'h0,         4'd4);
    vecs[7]  = mk(1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 6'b000000, 1'b1, 32'h20,        4'd4);
    vecs[8]  = mk(1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 6'b000000, 1'b0, 32'h20,        4'd4);
    vecs[9]  = mk(1'b0, 1'b0, 1'b1, 32'he,         32'hBFC0_0100, 1'b0, 6'b011111, 1'b0, 32'h20,        4'd4);
    vecs[10] = mk(1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 6'b000000, 1'b1, 32'hBFC0_0100, 4'd5);
    vecs[11] = mk(1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 6'b000000, 1'b0, 32'hBFC0_0100, 4'd5);
    vecs[12] = mk(1'b0, 1'b1, 1'b0, 32'h8,         32'h0,         1'b0, 6'b001111, 1'b0, 32'hBFC0_0100, 4'd5);
    vecs[13] = mk(1'b0, 1'b1, 1'b0, 32'h8,         32'h0,         1'b0, 6'b000000, 1'b1, 32'h20,        4'd6);
    vecs[14] = mk(1'b0, 1'b1, 1'b0, 32'h8,         32'h0,         1'b0, 6'b001111, 1'b0, 32'h20,        4'd6);
    vecs[15] = mk(1'b0, 1'b1, 1'b0, 32'he,         32'hCAFE_0000, 1'b0, 6'b001111, 1'b0, 32'h20,        4'd7);
    vecs[16] = mk(1'b0, 1'b1, 1'b0, 32'h0,         32'h0,         1'b0, 6'b000000, 1'b1, 32'hCAFE_0000, 4'd8);
    vecs[17] = mk(1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 6'b000000, 1'b0, 32'hCAFE_0000, 4'd8);
    vecs[18] = mk(1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         1'b1, 6'b000000, 1'b0, 32'hCAFE_0000, 4'd8);

    // Reset values before and across a clock edge.
    #3;
    check_all("reset_pre", 6'b000000, 1'b0, 32'h0, 4'd0);
    stallreq_from_mem = 1'b1;
    #1;
    chk("reset_stall_masked", {26'h0, stall}, 32'h0);
    stallreq_from_mem = 1'b0;
    step();
    check_all("reset_post_edge", 6'b000000, 1'b0, 32'h0, 4'd0);
    #2;
    rst = 1'b1;
    step();

    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].id, vecs[i].ex, vecs[i].mem, vecs[i].exc, vecs[i].epc, vecs[i].clr);
      #2;
      check_all($sformatf("vec%0d", i), vecs[i].e_stall, vecs[i].e_flush, vecs[i].e_pc,
                vecs[i].e_cnt);
      step();
    end
    chk("clr_result", {28'h0, perf_stall_cnt}, 32'h0);

    // Saturation: sixteen stall cycles from zero reach and hold all-ones.
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < 16; i++) step();
    chk("sat_16", {28'h0, perf_stall_cnt}, 32'hF);
    for (int i = 0; i < 3; i++) step();
    chk("sat_hold", {28'h0, perf_stall_cnt}, 32'hF);
    drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b1);
    step();
    chk("clr_with_stall", {28'h0, perf_stall_cnt}, 32'h0);
    drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
    step();
    chk("inc_after_clr", {28'h0, perf_stall_cnt}, 32'h1);

    // Asynchronous reset in the middle of a FLUSH cycle.
    drive(1'b1, 1'b0, 1'b0, 32'h8, 32'h0, 1'b0);
    step();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    #1;
    chk("pre_rst_flush", {31'h0, flush}, 32'h1);
    chk("pre_rst_pc", new_pc, 32'h20);
    #1;
    rst = 1'b0;
    #1;
    check_all("mid_flush_rst", 6'b000000, 1'b0, 32'h0, 4'd0);
    step();
    #2;
    rst = 1'b1;
    // Back in RUN: an exception right after release must be accepted at once.
    drive(1'b0, 1'b0, 1'b0, 32'he, 32'h0000_4444, 1'b0);
    step();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    #1;
    chk("after_rst_flush", {31'h0, flush}, 32'h1);
    chk("after_rst_pc", new_pc, 32'h0000_4444);
    step();
    chk("after_rst_holdoff", {31'h0, flush}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
